mdu_hilo: RTL

//   Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.

---
 rtl/mdu_hilo_if.sv | 28 ++
 rtl/mdu_hilo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - issue/readback bundle between the execute stage and the HI/LO multiply-divide unit
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             rd_en;
    logic             rd_sel;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             stall;

    modport master (
        output start, op, rs, rt, rd_en, rd_sel,
        input  rdata, hi, lo, busy, done, div_zero, stall
    );

    modport slave (
        input  start, op, rs, rt, rd_en, rd_sel,
        output rdata, hi, lo, busy, done, div_zero, stall
    );
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative MULT/DIV unit with HI/LO registers; signed MULT/DIV built only with MDU_SIGNED_EN
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    mdu_hilo_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opd;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_shf;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_dz;
    logic               r_done;
    logic               r_div_zero;

    logic               w_busy;
    logic               w_accept;
    logic               w_go;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_drem;
    logic [WIDTH:0]     w_ddiff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_busy   = (r_state != IDLE);
    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_go     = w_accept && !bus.op[2];

    // Multiply: {r_acc,r_shf} is the shifting product. Divide: r_acc is the partial remainder, r_shf dividend/quotient.
    assign w_msum  = {1'b0, r_acc} + {1'b0, (r_shf[0] ? r_opd : '0)};
    assign w_drem  = {r_acc, r_shf[WIDTH-1]};
    assign w_ddiff = w_drem - {1'b0, r_opd};
    assign w_prod  = {r_acc, r_shf};

`ifdef MDU_SIGNED_EN
    logic w_rs_neg;
    logic w_rt_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_rs_neg   = bus.op[0] & bus.rs[WIDTH-1];
    assign w_rt_neg   = bus.op[0] & bus.rt[WIDTH-1];
    assign w_rs_mag   = w_rs_neg ? ('0 - bus.rs) : bus.rs;
    assign w_rt_mag   = w_rt_neg ? ('0 - bus.rt) : bus.rt;
    assign w_prod_fix = r_neg_q ? ('0 - w_prod) : w_prod;
    assign w_quo_fix  = r_dz ? '1 : (r_neg_q ? ('0 - r_shf) : r_shf);
    assign w_rem_fix  = r_neg_r ? ('0 - r_acc) : r_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_go) begin
            r_neg_q <= w_rs_neg ^ w_rt_neg;
            r_neg_r <= w_rs_neg;
        end
    end
`else
    assign w_rs_mag   = bus.rs;
    assign w_rt_mag   = bus.rt;
    assign w_prod_fix = w_prod;
    assign w_quo_fix  = w_quo_fix_raw();
    assign w_rem_fix  = r_acc;

    function automatic logic [WIDTH-1:0] w_quo_fix_raw();
        return r_shf;
    endfunction
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_go) w_next = RUN;
            RUN:     if (r_cnt == '0) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_opd      <= '0;
            r_acc      <= '0;
            r_shf      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_is_div <= bus.op[1];
                        r_dz     <= bus.op[1] && (bus.rt == '0);
                        r_opd    <= bus.op[1] ? w_rt_mag : w_rs_mag;
                        r_shf    <= bus.op[1] ? w_rs_mag : w_rt_mag;
                        r_acc    <= '0;
                        r_cnt    <= CNT_W'(WIDTH - 1);
                    end else if (w_accept && bus.op == 3'b100) begin
                        r_hi <= bus.rs;
                    end else if (w_accept && bus.op == 3'b101) begin
                        r_lo <= bus.rs;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_ddiff[WIDTH] ? w_drem[WIDTH-1:0] : w_ddiff[WIDTH-1:0];
                        r_shf <= {r_shf[WIDTH-2:0], ~w_ddiff[WIDTH]};
                    end else begin
                        r_acc <= w_msum[WIDTH:1];
                        r_shf <= {w_msum[0], r_shf[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_done     <= 1'b1;
                    r_div_zero <= r_is_div & r_dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.rdata    = bus.rd_sel ? r_hi : r_lo;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.stall    = w_busy & (bus.start | bus.rd_en);
endmodule
